alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Drives the combinational 8-bit ALU, the consumer/issuer end of its operand/control interface.
//  Accepts 8- or 16-bit op requests from the CPU control path via a valid/ready handshake.
//  Issues one (narrow) or two (wide, low byte then high byte) ALU passes, chaining carry.
//  Holds the architectural flags register (Z,N,C,O).
//  Returns the result on a valid/ready response channel.
// PARAMETERS
//  WIDE_EN      1  1: req_wide honoured; 0: every request is a single 8-bit pass.
//  CMP_NOWRITE  1  1: a pass that asserts alu_cmpo drives rsp_write=0 (flags still update).
// PORTS
//  clk          in   1   system clock; all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   block can accept (IDLE only)
//  req_op       in   8   ALU control word (ALU ROM index), issued unchanged on every pass
//  req_wide     in   1   16-bit operation
//  req_a        in   16  operand A (bits 15:8 ignored when narrow)
//  req_b        in   16  operand B (bits 15:8 ignored when narrow)
//  alu_a        out  8   to ALU operand a
//  alu_b        out  8   to ALU operand b
//  alu_cins     out  8   to ALU control index
//  alu_oe       out  1   to ALU output enable
//  alu_carryin  out  1   to ALU carry in
//  alu_result   in   8   from ALU result
//  alu_carryout in   1   from ALU carry out
//  alu_overout  in   1   from ALU overflow
//  alu_cmpo     in   1   from ALU compare flag
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   consumer accepts response
//  rsp_result   out  16  result; bits 15:8 zero for narrow ops
//  rsp_write    out  1   result must be written back
//  clr_c        in   1   synchronous clear of flag C
//  flag_z       out  1   Z flag
//  flag_n       out  1   N flag
//  flag_c       out  1   C flag
//  flag_o       out  1   O flag
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready=1; flags 0; operand/result regs 0.
//  FSM IDLE -> EXEC_LO -> [EXEC_HI if wide] -> RESP -> IDLE.
//  IDLE: req_ready=1; on req_valid capture op/a/b/wide (wide &= WIDE_EN); go EXEC_LO.
//  EXEC_LO: alu_oe=1, alu_a=a[7:0], alu_b=b[7:0], alu_cins=op, alu_carryin=flag_c.
//    Capture result/carryout/overout/cmpo at end of cycle.
//  EXEC_HI: alu_oe=1, alu_a=a[15:8], alu_b=b[15:8], alu_cins=op.
//    alu_carryin = carryout registered in EXEC_LO; capture at end of cycle.
//  Outside EXEC states: alu_oe=0, alu_a/alu_b/alu_cins/alu_carryin=0.
//  Flag update on the clock edge leaving the last EXEC state:
//    Z = all result bytes zero; N = MSB of top byte; C, O from the last pass.
//  RESP: rsp_valid=1 with rsp_result/rsp_write stable until rsp_ready; then go IDLE.
//  Latency, request accept to rsp_valid: narrow 2 cycles, wide 3 cycles.
//  Throughput: one op per 3 (narrow) / 4 (wide) cycles with rsp_ready held 1.
//  rsp_write = !(CMP_NOWRITE && cmpo of any pass).
//  clr_c applies in any state; if coincident with a flag update, the update wins.
//  Shift/AND ops when wide: each byte processed independently, with no cross-byte shift.
//  Carry still chains, gated by the ALU's own ROM.
//  rst_n low mid-operation: immediate return to reset values; the in-flight op is lost.
//    No response is issued.
//  req_valid while not IDLE: ignored (req_ready=0); the request must be held by the requester.
// STRUCTURE
//  Shared package jrb8_pkg:
//    FSM state enum (2 bits);
//    flag bit indices;
//    named control-word constants OP_ADD, OP_ADDC, OP_SUB, OP_CMP, OP_AND, OP_SHL (match ALU ROM).
//  One sub-module: alu_flags_reg (4 flag flops + Z/N derivation + clr_c priority).
//  The ALU itself is instantiated by the parent, not inside this block.
// TESTING (bench instantiates real ALU + ROM alongside alu_seq)
//  Narrow: OP_ADD a=8'h7F b=8'h01 -> rsp_result=16'h0080 at +2 cycles;
//    Z=0 N=1 C=0 O=1; rsp_write=1.
//  Wide: OP_ADD a=16'h00FF b=16'h0001 -> 16'h0100 at +3 cycles.
//    Low-pass carry chains into the high pass; Z=0 C=0.
//  Compare: OP_CMP a=8'h05 b=8'h05 -> rsp_write=0; Z=1; result not committed.
//  Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and result held stable.
//    req_ready=0 throughout; a new request is accepted only after the handshake.
//  Carry-in/clr_c: with C=1, OP_ADDC 8'h01+8'h01 -> 8'h03.
//    clr_c on the same edge as a flag update -> C takes the update value.
//  Reset: rst_n asserted in EXEC_HI -> IDLE, flags 0, no rsp_valid.
//    Next request completes normally.

Source files
------------

// File: rtl/jrb8_pkg.sv
// ---------------------------------------------------------------------------
// jrb8_pkg: types and constants shared by the ALU sequencer and its users.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package jrb8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC_LO = 2'd1,
        ST_EXEC_HI = 2'd2,
        ST_RESP    = 2'd3
    } seq_state_t;

    // Bit positions inside the packed {Z,N,C,O} flags vector
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_O = 0;

    // Control words, indices into the ALU ROM
    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_ADDC = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_CMP  = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_SHL  = 8'h05;

endpackage

`default_nettype wire

// File: rtl/alu_flags_reg.sv
// ---------------------------------------------------------------------------
// alu_flags_reg: architectural Z/N/C/O flags with clr_c, flag update has priority.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_flags_reg
    import jrb8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        update,
    input  logic        clr_c,
    input  logic        wide,
    input  logic [15:0] result,
    input  logic        carry,
    input  logic        over,
    output logic [3:0]  flags
);

    logic zero_next;
    logic neg_next;

    assign zero_next = wide ? (result == 16'h0000) : (result[7:0] == 8'h00);
    assign neg_next  = wide ? result[15] : result[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (update) begin
            flags[FLAG_Z] <= zero_next;
            flags[FLAG_N] <= neg_next;
            flags[FLAG_C] <= carry;
            flags[FLAG_O] <= over;
        end else if (clr_c) begin
            flags[FLAG_C] <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq: issues 8/16-bit requests to the 8-bit ALU as one or two chained passes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq
    import jrb8_pkg::*;
#(
    parameter bit WIDE_EN     = 1'b1,
    parameter bit CMP_NOWRITE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic        req_wide,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [7:0]  alu_cins,
    output logic        alu_oe,
    output logic        alu_carryin,
    input  logic [7:0]  alu_result,
    input  logic        alu_carryout,
    input  logic        alu_overout,
    input  logic        alu_cmpo,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_write,
    input  logic        clr_c,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_c,
    output logic        flag_o
);

    seq_state_t  state;
    logic [7:0]  a_hi;
    logic [7:0]  b_hi;
    logic [7:0]  res_lo;
    logic        wide_q;
    logic        cmp_lo;

    logic        flag_update;
    logic        hi_pass;
    logic [15:0] pass_result;
    logic [3:0]  flags;

    // Flags move on the edge that closes the last pass of the operation
    assign hi_pass     = (state == ST_EXEC_HI);
    assign flag_update = hi_pass || ((state == ST_EXEC_LO) && !wide_q);
    assign pass_result = hi_pass ? {alu_result, res_lo} : {8'h00, alu_result};

    alu_flags_reg u_flags (
        .clk    (clk),
        .rst_n  (rst_n),
        .update (flag_update),
        .clr_c  (clr_c),
        .wide   (hi_pass),
        .result (pass_result),
        .carry  (alu_carryout),
        .over   (alu_overout),
        .flags  (flags)
    );

    assign flag_z = flags[FLAG_Z];
    assign flag_n = flags[FLAG_N];
    assign flag_c = flags[FLAG_C];
    assign flag_o = flags[FLAG_O];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b1;
            a_hi        <= 8'h00;
            b_hi        <= 8'h00;
            res_lo      <= 8'h00;
            wide_q      <= 1'b0;
            cmp_lo      <= 1'b0;
            alu_a       <= 8'h00;
            alu_b       <= 8'h00;
            alu_cins    <= 8'h00;
            alu_oe      <= 1'b0;
            alu_carryin <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= 16'h0000;
            rsp_write   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_hi        <= req_a[15:8];
                        b_hi        <= req_b[15:8];
                        wide_q      <= req_wide & WIDE_EN;
                        req_ready   <= 1'b0;
                        alu_oe      <= 1'b1;
                        alu_a       <= req_a[7:0];
                        alu_b       <= req_b[7:0];
                        alu_cins    <= req_op;
                        // a clr_c on this edge empties C before the low pass sees it
                        alu_carryin <= flags[FLAG_C] & ~clr_c;
                        state       <= ST_EXEC_LO;
                    end
                end
                ST_EXEC_LO: begin
                    res_lo <= alu_result;
                    cmp_lo <= alu_cmpo;
                    if (wide_q) begin
                        alu_a       <= a_hi;
                        alu_b       <= b_hi;
                        alu_carryin <= alu_carryout;
                        state       <= ST_EXEC_HI;
                    end else begin
                        alu_oe      <= 1'b0;
                        alu_a       <= 8'h00;
                        alu_b       <= 8'h00;
                        alu_cins    <= 8'h00;
                        alu_carryin <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_result  <= {8'h00, alu_result};
                        rsp_write   <= !(CMP_NOWRITE && alu_cmpo);
                        state       <= ST_RESP;
                    end
                end
                ST_EXEC_HI: begin
                    alu_oe      <= 1'b0;
                    alu_a       <= 8'h00;
                    alu_b       <= 8'h00;
                    alu_cins    <= 8'h00;
                    alu_carryin <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_result  <= {alu_result, res_lo};
                    rsp_write   <= !(CMP_NOWRITE && (cmp_lo || alu_cmpo));
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_write <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
